// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, register sentinel, function-code
// limits and the instruction-length helpers. The fetch valP computation uses
// the same instr_len function, so encoder and fetch agree on instruction length.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] FUN_MAX_OPQ  = 4'd3;
  localparam logic [3:0] FUN_MAX_CMOV = 4'd6;
  localparam logic [3:0] FUN_MAX_JXX  = 4'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_e;

  // Instruction length in bytes; unknown codes are treated as a lone byte0.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:                 instr_len = 4'd1;
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ:     instr_len = 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         instr_len = 4'd10;
      I_JXX, I_CALL:                        instr_len = 4'd9;
      default:                              instr_len = 4'd1;
    endcase
  endfunction

  // True when the instruction carries a register byte.
  function automatic logic has_reg(input logic [3:0] icode);
    case (icode)
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ,
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:         has_reg = 1'b1;
      default:                              has_reg = 1'b0;
    endcase
  endfunction

  // True when the instruction carries an 8-byte constant.
  function automatic logic has_valc(input logic [3:0] icode);
    case (icode)
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_JXX, I_CALL:                        has_valc = 1'b1;
      default:                              has_valc = 1'b0;
    endcase
  endfunction

  // Legal icode/ifun combination; icodes C..F are never legal.
  function automatic logic fun_ok(input logic [3:0] icode, input logic [3:0] ifun);
    case (icode)
      I_OPQ:                                fun_ok = (ifun <= FUN_MAX_OPQ);
      I_CMOVXX:                             fun_ok = (ifun <= FUN_MAX_CMOV);
      I_JXX:                                fun_ok = (ifun <= FUN_MAX_JXX);
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ,
      I_MRMOVQ, I_CALL, I_RET, I_PUSHQ,
      I_POPQ:                               fun_ok = (ifun == 4'h0);
      default:                              fun_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_encode_if.sv
// Instruction-encoder bus: decoded-instruction handshake, pointer load,
// memory byte-write port and status. master = loader/harness, slave = encoder.
interface instr_encode_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [63:0]       valC;
  logic              ptr_load;
  logic [ADDR_W-1:0] ptr_val;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] next_pc;

  modport master (
    output in_valid, icode, ifun, rA, rB, valC, ptr_load, ptr_val,
    input  in_ready, wr_en, wr_addr, wr_data, done, err, next_pc
  );

  modport slave (
    input  in_valid, icode, ifun, rA, rB, valC, ptr_load, ptr_val,
    output in_ready, wr_en, wr_addr, wr_data, done, err, next_pc
  );
endinterface

// File: rtl/y86_ilen.sv
// Combinational icode decode: instruction length and which optional fields
// (register byte, 8-byte constant) are present.
module y86_ilen
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] len,
  output logic       has_reg_o,
  output logic       has_valc_o
);

  assign len        = instr_len(icode);
  assign has_reg_o  = has_reg(icode);
  assign has_valc_o = has_valc(icode);

endmodule

// File: rtl/instr_encode.sv
// Y86 instruction encoder / instruction-memory writer.
// Accepts one decoded instruction per handshake, serialises it into 1..10
// bytes and writes one byte per cycle at an internal write pointer.
// Optional build macro ENC_CHECK_EN: reject illegal icode/ifun combinations
// and instructions that would run past the top of memory (all-or-nothing).
module instr_encode
  import y86_pkg::*;
#(
  parameter int              ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  instr_encode_if.slave bus
);

  enc_state_e        state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [3:0]        cnt_r;
  logic [3:0]        len_r;
  logic [79:0]       shreg_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [7:0]        wr_data_r;
  logic              done_r;
  logic              err_r;

  logic [3:0]        len_s;
  logic              has_reg_s;
  logic              has_valc_s;
  logic [79:0]       frame_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              reject_s;
  logic              last_s;

  y86_ilen u_ilen (
    .icode      (bus.icode),
    .len        (len_s),
    .has_reg_o  (has_reg_s),
    .has_valc_o (has_valc_s)
  );

  // A pointer load owns the cycle; the cycle after a reject is also held off
  // so the rejected request is not seen twice.
  assign in_ready_s = (state_r == ST_IDLE) & ~bus.ptr_load & ~err_r;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign last_s     = (cnt_r == (len_r - 4'd1));

  assign bus.in_ready = in_ready_s;
  assign bus.wr_en    = wr_en_r;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = wr_data_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;
  assign bus.next_pc  = ptr_r;

  // Assemble the left-aligned byte frame: byte0, optional regs, big-endian valC.
  always_comb begin
    frame_s = 80'h0;
    case ({has_reg_s, has_valc_s})
      2'b11:   frame_s = {bus.icode, bus.ifun, bus.rB, bus.rA, bus.valC};
      2'b01:   frame_s = {bus.icode, bus.ifun, bus.valC, 8'h00};
      2'b10:   frame_s = {bus.icode, bus.ifun, bus.rB, bus.rA, 64'h0};
      default: frame_s = {bus.icode, bus.ifun, 72'h0};
    endcase
  end

`ifdef ENC_CHECK_EN
  localparam logic [ADDR_W+1:0] MEM_SIZE = {2'b01, {ADDR_W{1'b0}}};
  logic [ADDR_W+1:0] end_s;

  // Reject illegal encodings and instructions that would overrun memory.
  always_comb begin
    end_s    = {2'b00, ptr_r} + {{(ADDR_W-2){1'b0}}, len_s};
    reject_s = 1'b0;
    if (!fun_ok(bus.icode, bus.ifun) || (end_s > MEM_SIZE)) begin
      reject_s = 1'b1;
    end else begin
      reject_s = 1'b0;
    end
  end
`else
  assign reject_s = 1'b0;
`endif

  // Encoder FSM: latch on accept, emit one byte per cycle, advance the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ptr_r     <= BASE_ADDR;
      cnt_r     <= 4'd0;
      len_r     <= 4'd0;
      shreg_r   <= 80'h0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= 8'h00;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wr_en_r   <= 1'b0;
          done_r    <= 1'b0;
          err_r     <= 1'b0;
          wr_addr_r <= {ADDR_W{1'b0}};
          wr_data_r <= 8'h00;
          if (bus.ptr_load) begin
            ptr_r <= bus.ptr_val;
          end else if (accept_s) begin
            if (reject_s) begin
              err_r <= 1'b1;
            end else begin
              state_r   <= ST_EMIT;
              cnt_r     <= 4'd0;
              len_r     <= len_s;
              shreg_r   <= {frame_s[71:0], 8'h00};
              wr_en_r   <= 1'b1;
              wr_addr_r <= ptr_r;
              wr_data_r <= frame_s[79:72];
              done_r    <= (len_s == 4'd1);
            end
          end else begin
            ptr_r <= ptr_r;
          end
        end
        ST_EMIT: begin
          if (last_s) begin
            state_r   <= ST_IDLE;
            ptr_r     <= ptr_r + ADDR_W'(len_r);
            cnt_r     <= 4'd0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= 8'h00;
            done_r    <= 1'b0;
          end else begin
            cnt_r     <= cnt_r + 4'd1;
            wr_addr_r <= wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            wr_data_r <= shreg_r[79:72];
            shreg_r   <= {shreg_r[71:0], 8'h00};
            done_r    <= ((cnt_r + 4'd2) == len_r);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          wr_en_r <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode.sv
// Directed self-checking bench for instr_encode (8-bit address space).
// Covers reset, irmovq/halt/opq/call encodings, pointer load priority,
// wrap or reject at the top of memory (ENC_CHECK_EN), and async reset mid-emit.
module tb_instr_encode;
  import y86_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] exp_ptr;

  instr_encode_if #(.ADDR_W(8)) bus ();

  instr_encode #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc);
    bus.icode    = ic;
    bus.ifun     = fn;
    bus.rA       = ra;
    bus.rB       = rb;
    bus.valC     = vc;
    bus.in_valid = 1'b1;
  endtask

  // Starts and ends on a falling edge so consecutive calls are back-to-back.
  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input int len,
                       input logic [79:0] exp);
    logic [7:0] a;
    drive(ic, fn, ra, rb, vc);
    #1 chk("ready_before", {63'h0, bus.in_ready}, 64'h1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      a = exp_ptr + 8'(i);
      chk("wr_en", {63'h0, bus.wr_en}, 64'h1);
      chk("wr_addr", {56'h0, bus.wr_addr}, {56'h0, a});
      chk("wr_data", {56'h0, bus.wr_data}, {56'h0, exp[79-8*i -: 8]});
      chk("done", {63'h0, bus.done}, (i == len-1) ? 64'h1 : 64'h0);
      chk("ready_busy", {63'h0, bus.in_ready}, 64'h0);
    end
    @(negedge clk);
    exp_ptr = exp_ptr + 8'(len);
    chk("wr_en_after", {63'h0, bus.wr_en}, 64'h0);
    chk("done_after", {63'h0, bus.done}, 64'h0);
    chk("ready_after", {63'h0, bus.in_ready}, 64'h1);
    chk("next_pc", {56'h0, bus.next_pc}, {56'h0, exp_ptr});
  endtask

  // Pointer load with a competing in_valid that must not be accepted.
  task automatic load_ptr(input logic [7:0] v);
    drive(I_NOP, 4'h0, RNONE, RNONE, 64'h0);
    bus.ptr_load = 1'b1;
    bus.ptr_val  = v;
    #1 chk("ready_on_load", {63'h0, bus.in_ready}, 64'h0);
    @(posedge clk);
    #1 bus.ptr_load = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    exp_ptr = v;
    chk("no_write_on_load", {63'h0, bus.wr_en}, 64'h0);
    chk("ptr_loaded", {56'h0, bus.next_pc}, {56'h0, exp_ptr});
  endtask

`ifdef ENC_CHECK_EN
  task automatic expect_reject(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc);
    drive(ic, fn, RNONE, RNONE, vc);
    #1 chk("ready_before_rej", {63'h0, bus.in_ready}, 64'h1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse", {63'h0, bus.err}, 64'h1);
    chk("rej_no_write", {63'h0, bus.wr_en}, 64'h0);
    chk("rej_ready_low", {63'h0, bus.in_ready}, 64'h0);
    @(negedge clk);
    chk("err_clear", {63'h0, bus.err}, 64'h0);
    chk("rej_no_write2", {63'h0, bus.wr_en}, 64'h0);
    chk("rej_ready_back", {63'h0, bus.in_ready}, 64'h1);
    chk("rej_ptr_same", {56'h0, bus.next_pc}, {56'h0, exp_ptr});
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    exp_ptr = 8'h00;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.icode = 4'h0; bus.ifun = 4'h0; bus.rA = 4'h0; bus.rB = 4'h0;
    bus.valC = 64'h0; bus.ptr_load = 1'b0; bus.ptr_val = 8'h00;

    @(negedge clk);
    chk("rst_wr_en", {63'h0, bus.wr_en}, 64'h0);
    chk("rst_done", {63'h0, bus.done}, 64'h0);
    chk("rst_err", {63'h0, bus.err}, 64'h0);
    chk("rst_addr", {56'h0, bus.wr_addr}, 64'h0);
    chk("rst_data", {56'h0, bus.wr_data}, 64'h0);
    chk("rst_next_pc", {56'h0, bus.next_pc}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // irmovq $0x100, %rdx at 0x00
    issue(I_IRMOVQ, 4'h0, RNONE, 4'h2, 64'h100, 10, 80'h302F_0000_0000_0000_0100);
    // back-to-back halt then addq %rbx,%rcx
    issue(I_HALT, 4'h0, RNONE, RNONE, 64'h0, 1, 80'h0);
    issue(I_OPQ, 4'h0, 4'h3, 4'h1, 64'h0, 2, 80'h6013_0000_0000_0000_0000);
    chk("pc_after_opq", {56'h0, bus.next_pc}, 64'h0D);

    // call at 0x40
    load_ptr(8'h40);
    issue(I_CALL, 4'h0, RNONE, RNONE, 64'h0102030405060708, 9, 80'h80_0102030405060708_00);
    chk("pc_after_call", {56'h0, bus.next_pc}, 64'h49);

`ifdef ENC_CHECK_EN
    expect_reject(4'hD, 4'h0, 64'h0);
    expect_reject(I_OPQ, 4'h4, 64'h0);
    load_ptr(8'hFA);
    expect_reject(I_JXX, 4'h0, 64'h1122334455667788);
`else
    load_ptr(8'hFA);
    issue(I_JXX, 4'h0, RNONE, RNONE, 64'h1122334455667788, 9, 80'h70_1122334455667788_00);
    chk("pc_after_wrap", {56'h0, bus.next_pc}, 64'h03);
`endif

    // rmmovq at 0x20, reset while byte 5 is on the bus
    load_ptr(8'h20);
    drive(I_RMMOVQ, 4'h0, 4'h1, 4'h2, 64'h1122334455667788);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pre_rst_wr_en", {63'h0, bus.wr_en}, 64'h1);
      chk("pre_rst_addr", {56'h0, bus.wr_addr}, 64'h20 + 64'(i));
    end
    chk("byte5_data", {56'h0, bus.wr_data}, 64'h33);
    rst = 1'b1;
    #1;
    chk("async_wr_en", {63'h0, bus.wr_en}, 64'h0);
    chk("async_addr", {56'h0, bus.wr_addr}, 64'h0);
    chk("async_data", {56'h0, bus.wr_data}, 64'h0);
    chk("async_done", {63'h0, bus.done}, 64'h0);
    chk("async_next_pc", {56'h0, bus.next_pc}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {63'h0, bus.in_ready}, 64'h1);
    chk("idle_after_rst", {63'h0, bus.wr_en}, 64'h0);
    exp_ptr = 8'h00;
    @(negedge clk);
    issue(I_NOP, 4'h0, RNONE, RNONE, 64'h0, 1, 80'h10_0000_0000_0000_0000_00);
    chk("pc_after_nop", {56'h0, bus.next_pc}, 64'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encode.md
# instr_encode

Y86 instruction encoder and instruction-memory writer: the producer side of the fetch unit's byte format. It accepts one decoded instruction (icode, ifun, rA, rB, valC) per handshake, serialises it into 1–10 bytes, and writes one byte per cycle into instruction memory at an internal write pointer. It sits between the program loader or test harness and the instruction memory that fetch reads.

## Interface
- ADDR_W, 8, instruction-memory address width; depth is 2^ADDR_W bytes.
- BASE_ADDR, 0, write-pointer value after reset.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction fields are valid.
- in_ready  out  1  encoder can accept; high only in IDLE.
- icode  in  4  instruction code.
- ifun  in  4  function code.
- rA  in  4  register A id; 0xF means none.
- rB  in  4  register B id; 0xF means none.
- valC  in  64  constant, immediate or displacement.
- ptr_load  in  1  load write pointer; honoured only in IDLE.
- ptr_val  in  ADDR_W  new write-pointer value.
- wr_en  out  1  memory byte write strobe.
- wr_addr  out  ADDR_W  byte address.
- wr_data  out  8  byte data.
- done  out  1  one-cycle pulse with the last byte of an instruction.
- err  out  1  one-cycle pulse when an instruction is rejected.
- next_pc  out  ADDR_W  current write pointer, i.e. valP of the last encoded instruction.

## Operation
- Byte format:
  - byte0 = {icode, ifun}.
  - Register byte = {rB[7:4], rA[3:0]}.
  - valC is big-endian: first emitted byte is valC[63:56].
- Lengths by icode:
  - 0 halt, 1 nop, 9 ret: 1 byte (byte0).
  - 2 cmov, 6 opq, A pushq, B popq: 2 bytes (byte0, register byte).
  - 3 irmovq, 4 rmmovq, 5 mrmovq: 10 bytes (byte0, register byte, valC).
  - 7 jXX, 8 call: 9 bytes (byte0, valC).
- FSM states:
  - IDLE: in_ready=1. Transitions to EMIT on accept (in_valid & in_ready).
  - EMIT: byte counter runs 0..len-1. Returns to IDLE after byte len-1.
- On accept, the fields are latched into a 10-byte shift register. The length comes from a combinational lookup.
- In EMIT: wr_en=1, wr_addr=ptr+cnt, wr_data=byte[cnt].
- On the last byte: done=1, and ptr advances by len modulo 2^ADDR_W.
- ptr_load in IDLE: ptr←ptr_val. It wins over in_valid in the same cycle; in_ready is forced low that cycle. ptr_load in EMIT is ignored.
- Reset (including mid-EMIT):
  - State IDLE; ptr=BASE_ADDR; cnt=0.
  - wr_en, done, err, wr_addr, wr_data = 0.
  - Any partially written instruction stays in memory; no rollback.

## Timing
- Accept at edge T. Bytes are written on cycles T+1 .. T+len, one per cycle, with no gaps.
- done is high in cycle T+len. in_ready returns high in cycle T+len+1.
- Throughput: len+1 cycles per instruction.
- next_pc updates on the edge ending the done cycle.
- Rejected instruction: err pulses in cycle T+1, no wr_en, ptr unchanged, state stays IDLE, in_ready high again at T+2.
- Outputs are registered except in_ready, which is a decode of the state and ptr_load.

## Configuration
- ENC_CHECK_EN defined → an instruction is rejected (err) if any of these hold:
  - icode is C–F.
  - ifun is nonzero for an icode other than 2, 6, 7.
  - ifun > 3 for opq.
  - ifun > 6 for cmov or jXX.
  - ptr+len > 2^ADDR_W (overflow). An overflowing instruction writes no bytes (all-or-nothing).
- ENC_CHECK_EN undefined → no checks; err is tied 0.
  - icode C–F is encoded as 1 byte.
  - Addresses wrap modulo 2^ADDR_W.

## Structure
- Shared package y86_pkg:
  - icode constants (I_HALT..I_POPQ).
  - RNONE = 4'hF.
  - Function-code limits.
  - Instruction-length function. The same function is used by the fetch valP computation, so the two cannot diverge.
- Sub-module y86_ilen: combinational icode → length (1/2/9/10) and has_reg/has_valC flags, all drawn from the package.

## Test plan
- Reset, then irmovq (icode 3, ifun 0, rA F, rB 2, valC 0x100) at ptr 0 → writes 0x30, 0x2F, 00, 00, 00, 00, 00, 00, 0x01, 0x00 to addresses 0–9 on cycles T+1..T+10; done at T+10; next_pc=0x0A.
- Back-to-back halt then opq addq (6,0, rA 3, rB 1) → 0x00 at 0x0A; then 0x60, 0x13 at 0x0B–0x0C; in_ready low exactly during emission.
- call (8, valC 0x0102030405060708) after ptr_load 0x40 → 0x80, 01..08 at 0x40–0x48; next_pc=0x49; simultaneous in_valid with ptr_load is not accepted.
- With ENC_CHECK_EN: icode 0xD → err pulse, no writes, next_pc unchanged. jXX at ptr 0xFA (needs 9 bytes) → err, no writes.
- Without ENC_CHECK_EN: jXX at ptr 0xFA → bytes at 0xFA–0xFF then 0x00–0x02; next_pc=0x03.
- rst asserted during byte 5 of an rmmovq → wr_en drops immediately (async); next_pc=BASE_ADDR; in_ready high on the first edge after release.
